// File: rtl/instr_imm_encoder_pkg.sv
// Shared core definitions for the immediate encoder and decoder: type codes,
// immediate range limits, FIFO states and the buffered entry layout.
package instr_imm_encoder_pkg;

    typedef enum logic [2:0] {
        IMM_NONE   = 3'b000,
        IMM_I      = 3'b001,
        IMM_S      = 3'b010,
        IMM_B      = 3'b011,
        IMM_U      = 3'b100,
        IMM_J      = 3'b101,
        IMM_I_LOAD = 3'b110,
        IMM_I_ALT  = 3'b111
    } imm_type_e;

    localparam logic signed [31:0] IMM12_MIN = -32'sd2048;
    localparam logic signed [31:0] IMM12_MAX = 32'sd2047;
    localparam logic signed [31:0] IMM_B_MIN = -32'sd4096;
    localparam logic signed [31:0] IMM_B_MAX = 32'sd4094;
    localparam logic signed [31:0] IMM_J_MIN = -32'sd1048576;
    localparam logic signed [31:0] IMM_J_MAX = 32'sd1048574;

    typedef enum logic [1:0] {
        FIFO_EMPTY = 2'd0,
        FIFO_ONE   = 2'd1,
        FIFO_FULL  = 2'd2
    } fifo_state_e;

    typedef struct packed {
        logic [31:0] instr;
        logic        err;
    } enc_entry_t;

    function automatic logic outOfRange(input logic signed [31:0] value,
                                        input logic signed [31:0] lo,
                                        input logic signed [31:0] hi);
        return (value < lo) || (value > hi);
    endfunction

endpackage

// File: rtl/instr_imm_encoder_imm_field_packer.sv
// Scatters a signed immediate into the instruction fields for its format and
// flags values the format cannot represent; the packing is truncated on error.
module imm_field_packer
    import instr_imm_encoder_pkg::*;
(
    input  logic [31:0] base_i,
    input  logic [31:0] imm_i,
    input  imm_type_e   imm_type_i,
    output logic [31:0] instr_o,
    output logic        err_o
);

    logic signed [31:0] immVal;

    assign immVal = signed'(imm_i);

    always_comb begin
        instr_o = base_i;
        err_o   = 1'b0;
        unique case (imm_type_i)
            IMM_NONE: begin
                err_o = (imm_i != 32'd0);
            end
            IMM_I, IMM_I_LOAD, IMM_I_ALT: begin
                instr_o[31:20] = imm_i[11:0];
                err_o          = outOfRange(immVal, IMM12_MIN, IMM12_MAX);
            end
            IMM_S: begin
                instr_o[31:25] = imm_i[11:5];
                instr_o[11:7]  = imm_i[4:0];
                err_o          = outOfRange(immVal, IMM12_MIN, IMM12_MAX);
            end
            // Branch and jump offsets are halfword aligned, so bit 0 is never encoded.
            IMM_B: begin
                instr_o[31]    = imm_i[12];
                instr_o[30:25] = imm_i[10:5];
                instr_o[11:8]  = imm_i[4:1];
                instr_o[7]     = imm_i[11];
                err_o          = outOfRange(immVal, IMM_B_MIN, IMM_B_MAX) || imm_i[0];
            end
            IMM_U: begin
                instr_o[31:12] = imm_i[31:12];
                err_o          = (imm_i[11:0] != 12'd0);
            end
            IMM_J: begin
                instr_o[31]    = imm_i[20];
                instr_o[30:21] = imm_i[10:1];
                instr_o[20]    = imm_i[11];
                instr_o[19:12] = imm_i[19:12];
                err_o          = outOfRange(immVal, IMM_J_MIN, IMM_J_MAX) || imm_i[0];
            end
        endcase
    end

endmodule

// File: rtl/instr_imm_encoder.sv
// Immediate encoder with a 2-entry output FIFO and a saturating error counter;
// ready_in depends only on FIFO occupancy so it never combinationally follows ready_out.
module instr_imm_encoder
    import instr_imm_encoder_pkg::*;
(
    input  logic        clk_in,
    input  logic        reset_in,
    input  logic        valid_in,
    output logic        ready_in,
    input  logic [31:0] base_in,
    input  logic [31:0] imm_in,
    input  logic [2:0]  imm_type_in,
    output logic [31:0] instr_out,
    output logic        err_out,
    output logic        valid_out,
    input  logic        ready_out,
    output logic [7:0]  err_count_out
);

    fifo_state_e state_q, state_d;
    enc_entry_t  headEntry_q, headEntry_d;
    enc_entry_t  tailEntry_q, tailEntry_d;
    enc_entry_t  newEntry;
    logic [7:0]  errCount_q, errCount_d;
    logic        push, pop;

    imm_field_packer u_packer (
        .base_i     (base_in),
        .imm_i      (imm_in),
        .imm_type_i (imm_type_e'(imm_type_in)),
        .instr_o    (newEntry.instr),
        .err_o      (newEntry.err)
    );

    assign push = valid_in && ready_in;
    assign pop  = valid_out && ready_out;

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            state_q     <= FIFO_EMPTY;
            headEntry_q <= '0;
            tailEntry_q <= '0;
            errCount_q  <= 8'd0;
        end else begin
            state_q     <= state_d;
            headEntry_q <= headEntry_d;
            tailEntry_q <= tailEntry_d;
            errCount_q  <= errCount_d;
        end
    end

    // The head register drives the outputs directly, so it only changes on a pop or an empty-slot fill.
    always_comb begin
        state_d     = state_q;
        headEntry_d = headEntry_q;
        tailEntry_d = tailEntry_q;
        unique case (state_q)
            FIFO_EMPTY: begin
                if (push) begin
                    headEntry_d = newEntry;
                    state_d     = FIFO_ONE;
                end
            end
            FIFO_ONE: begin
                unique case ({push, pop})
                    2'b10: begin
                        tailEntry_d = newEntry;
                        state_d     = FIFO_FULL;
                    end
                    2'b01: state_d = FIFO_EMPTY;
                    2'b11: headEntry_d = newEntry;
                    default: state_d = FIFO_ONE;
                endcase
            end
            FIFO_FULL: begin
                if (pop) begin
                    headEntry_d = tailEntry_q;
                    state_d     = FIFO_ONE;
                end
            end
            default: state_d = FIFO_EMPTY;
        endcase
    end

    always_comb begin
        errCount_d = errCount_q;
        if (push && newEntry.err && (errCount_q != 8'hFF)) begin
            errCount_d = errCount_q + 8'd1;
        end
    end

    always_comb begin
        ready_in      = (state_q != FIFO_FULL);
        valid_out     = (state_q != FIFO_EMPTY);
        instr_out     = headEntry_q.instr;
        err_out       = headEntry_q.err;
        err_count_out = errCount_q;
    end

endmodule

// File: tb/tb_instr_imm_encoder.sv
// Self-checking bench for instr_imm_encoder: directed cases, backpressure,
// counter saturation, reset while full and randomized traffic against a queue model.
module tb_instr_imm_encoder;

    logic        clk;
    logic        rst;
    logic        validIn;
    logic        readyIn;
    logic [31:0] baseIn;
    logic [31:0] immIn;
    logic [2:0]  immType;
    logic [31:0] instrOut;
    logic        errOut;
    logic        validOut;
    logic        readyOut;
    logic [7:0]  errCountOut;

    int checkCount = 0;
    int passCount  = 0;
    int failCount  = 0;

    typedef struct {
        logic [31:0] instr;
        logic        err;
    } model_entry_t;

    model_entry_t modelQ[$];
    int           modelErrCount = 0;

    int boundary[16] = '{0, 1, -1, 2047, 2048, -2048, -2049, 4094, 4095, 4096,
                         -4096, -4098, 1048574, 1048576, -1048576, 4096 * 3};

    instr_imm_encoder dut (
        .clk_in        (clk),
        .reset_in      (rst),
        .valid_in      (validIn),
        .ready_in      (readyIn),
        .base_in       (baseIn),
        .imm_in        (immIn),
        .imm_type_in   (immType),
        .instr_out     (instrOut),
        .err_out       (errOut),
        .valid_out     (validOut),
        .ready_out     (readyOut),
        .err_count_out (errCountOut)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: observed timeout expected finish");
        $fatal(1, "[TB] simulation did not finish");
    end

    // Which immediate bit lands in instruction bit p for a format, or -1 when p belongs to the template.
    function automatic int srcBit(input logic [2:0] typ, input int p);
        case (typ)
            3'd1, 3'd6, 3'd7: return (p >= 20) ? p - 20 : -1;
            3'd2: begin
                if (p >= 25) return p - 20;
                if (p >= 7 && p <= 11) return p - 7;
                return -1;
            end
            3'd3: begin
                if (p == 31) return 12;
                if (p >= 25) return p - 20;
                if (p >= 8 && p <= 11) return p - 7;
                if (p == 7) return 11;
                return -1;
            end
            3'd4: return (p >= 12) ? p : -1;
            3'd5: begin
                if (p == 31) return 20;
                if (p >= 21) return p - 20;
                if (p == 20) return 11;
                if (p >= 12 && p <= 19) return p;
                return -1;
            end
            default: return -1;
        endcase
    endfunction

    function automatic void modelEncode(input logic [31:0] base, input logic [31:0] imm,
                                        input logic [2:0] typ,
                                        output logic [31:0] instr, output logic err);
        int v;
        int s;
        v     = imm;
        instr = base;
        for (int p = 0; p < 32; p++) begin
            s = srcBit(typ, p);
            if (s >= 0) instr[p] = imm[s];
        end
        case (typ)
            3'd0:                   err = (v != 0);
            3'd1, 3'd2, 3'd6, 3'd7: err = (v < -2048) || (v > 2047);
            3'd3:                   err = (v < -4096) || (v > 4094) || (v % 2 != 0);
            3'd4:                   err = (v % 4096 != 0);
            default:                err = (v < -1048576) || (v > 1048574) || (v % 2 != 0);
        endcase
    endfunction

    function automatic logic [31:0] randImm();
        int sel;
        sel = $urandom_range(0, 3);
        case (sel)
            0:       return 32'($urandom_range(0, 8191)) - 32'd4096;
            1:       return $urandom();
            2:       return 32'(boundary[$urandom_range(0, 15)]);
            default: return $urandom() & 32'hFFFFF000;
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Drives one cycle of inputs, checks the visible FIFO head, then advances the model past the edge.
    task automatic applyStimulus(input logic v, input logic [31:0] base, input logic [31:0] imm,
                                 input logic [2:0] typ, input logic rOut);
        logic [31:0] expInstr;
        logic        expErr;
        logic        expReady;
        logic        doPush;
        logic        doPop;
        validIn  = v;
        baseIn   = base;
        immIn    = imm;
        immType  = typ;
        readyOut = rOut;
        #1;
        expReady = (modelQ.size() < 2);
        checkOutput("ready_in", 32'(readyIn), 32'(expReady));
        checkOutput("valid_out", 32'(validOut), 32'(modelQ.size() > 0));
        if (modelQ.size() > 0) begin
            checkOutput("instr_out", instrOut, modelQ[0].instr);
            checkOutput("err_out", 32'(errOut), 32'(modelQ[0].err));
        end
        doPop  = (modelQ.size() > 0) && rOut;
        doPush = v && expReady;
        modelEncode(base, imm, typ, expInstr, expErr);
        @(posedge clk);
        #1;
        if (doPop) void'(modelQ.pop_front());
        if (doPush) begin
            modelQ.push_back('{expInstr, expErr});
            if (expErr && modelErrCount < 255) modelErrCount++;
        end
        checkOutput("err_count_out", 32'(errCountOut), 32'(modelErrCount));
    endtask

    task automatic doDirected(input string tag, input logic [31:0] base, input logic [31:0] imm,
                              input logic [2:0] typ, input logic [31:0] wantInstr,
                              input logic wantErr);
        applyStimulus(1'b1, base, imm, typ, 1'b1);
        checkOutput({tag, " valid"}, 32'(validOut), 32'd1);
        checkOutput({tag, " instr"}, instrOut, wantInstr);
        checkOutput({tag, " err"}, 32'(errOut), 32'(wantErr));
    endtask

    initial begin
        rst      = 1'b1;
        validIn  = 1'b0;
        baseIn   = 32'd0;
        immIn    = 32'd0;
        immType  = 3'd0;
        readyOut = 1'b0;
        #3;
        checkOutput("reset valid_out", 32'(validOut), 32'd0);
        checkOutput("reset instr_out", instrOut, 32'd0);
        checkOutput("reset err_out", 32'(errOut), 32'd0);
        checkOutput("reset err_count", 32'(errCountOut), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("ready_in after reset", 32'(readyIn), 32'd1);

        $display("[TB] directed encodings");
        doDirected("I -1", 32'h00000013, 32'hFFFFFFFF, 3'd1, 32'hFFF00013, 1'b0);
        doDirected("B 8", 32'h00000063, 32'd8, 3'd3, 32'h00000463, 1'b0);
        doDirected("J 2048", 32'h0000006F, 32'd2048, 3'd5, 32'h0010006F, 1'b0);
        doDirected("U ok", 32'h00000037, 32'h12345000, 3'd4, 32'h12345037, 1'b0);
        doDirected("U low bits", 32'h00000037, 32'h12345001, 3'd4, 32'h12345037, 1'b1);
        checkOutput("err_count after U", 32'(errCountOut), 32'd1);
        doDirected("I 2048", 32'h00000013, 32'd2048, 3'd1, 32'h80000013, 1'b1);
        doDirected("B odd", 32'h00000063, 32'd5, 3'd3, 32'h00000263, 1'b1);
        doDirected("none nonzero", 32'hDEADBEEF, 32'd4, 3'd0, 32'hDEADBEEF, 1'b1);
        checkOutput("err_count after range", 32'(errCountOut), 32'd4);
        applyStimulus(1'b0, 32'd0, 32'd0, 3'd0, 1'b1);
        applyStimulus(1'b0, 32'd0, 32'd0, 3'd0, 1'b1);

        $display("[TB] backpressure");
        applyStimulus(1'b1, 32'h00000013, 32'd1, 3'd1, 1'b0);
        applyStimulus(1'b1, 32'h00000013, 32'd2, 3'd1, 1'b0);
        checkOutput("bp ready_in low", 32'(readyIn), 32'd0);
        checkOutput("bp head", instrOut, 32'h00100013);
        applyStimulus(1'b1, 32'h00000013, 32'd3, 3'd1, 1'b0);
        checkOutput("bp head stable", instrOut, 32'h00100013);
        applyStimulus(1'b1, 32'h00000013, 32'd3, 3'd1, 1'b1);
        checkOutput("bp second out", instrOut, 32'h00200013);
        applyStimulus(1'b1, 32'h00000013, 32'd3, 3'd1, 1'b1);
        checkOutput("bp third out", instrOut, 32'h00300013);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 32'd0, 32'd0, 3'd0, 1'b1);

        $display("[TB] error counter saturation");
        for (int i = 0; i < 260; i++) applyStimulus(1'b1, 32'h00000013, 32'd4096, 3'd1, 1'b1);
        checkOutput("err_count saturated", 32'(errCountOut), 32'd255);
        for (int i = 0; i < 2; i++) applyStimulus(1'b0, 32'd0, 32'd0, 3'd0, 1'b1);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 400; i++) begin
            applyStimulus(1'($urandom_range(0, 3) != 0), $urandom(), randImm(),
                          3'($urandom_range(0, 7)), 1'($urandom_range(0, 2) != 0));
        end
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 32'd0, 32'd0, 3'd0, 1'b1);

        $display("[TB] reset while full");
        applyStimulus(1'b1, 32'h00000063, 32'd5, 3'd3, 1'b0);
        applyStimulus(1'b1, 32'h00000013, 32'd7, 3'd1, 1'b0);
        checkOutput("full ready_in", 32'(readyIn), 32'd0);
        validIn = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        modelQ.delete();
        modelErrCount = 0;
        checkOutput("mid reset valid_out", 32'(validOut), 32'd0);
        checkOutput("mid reset instr_out", instrOut, 32'd0);
        checkOutput("mid reset err_count", 32'(errCountOut), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("post reset ready_in", 32'(readyIn), 32'd1);
        checkOutput("post reset valid_out", 32'(validOut), 32'd0);
        doDirected("after reset", 32'h00000013, 32'hFFFFFFFF, 3'd1, 32'hFFF00013, 1'b0);
        applyStimulus(1'b0, 32'd0, 32'd0, 3'd0, 1'b1);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
